// File: rtl/dual_driver_checker.sv
// Registered monitor for a two-output submodule pair: flags e/f disagreement,
// counts mismatching samples and latches a sticky fault after HOLD consecutive ones.
module dual_driver_checker #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned HOLD  = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_e_in,
    input  logic             i_f_in,
    output logic             o_e_q,
    output logic             o_f_q,
    output logic             o_mismatch,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_mm_count,
    output logic [1:0]       o_state
);

    localparam int unsigned RUN_W = $clog2(HOLD + 1);
    localparam logic [RUN_W:0] HOLD_V = (RUN_W + 1)'(HOLD);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        AGREE    = 2'd1,
        MISMATCH = 2'd2,
        FAULT    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    state_t           w_first_mm;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] w_run_nxt;
    logic [RUN_W:0]   w_run_inc;
    logic             w_mm;
    logic             r_e_q;
    logic             r_f_q;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_mm_count;

    assign w_mm       = i_e_in ^ i_f_in;
    assign w_run_inc  = {1'b0, r_run} + (RUN_W + 1)'(1);
    assign w_first_mm = (HOLD == 1) ? FAULT : MISMATCH;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_run   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
        end
    end

    // Next-state logic; clear beats any same-cycle transition
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        if (i_clr) begin
            w_state_nxt = IDLE;
            w_run_nxt   = '0;
        end else if (i_en) begin
            case (r_state)
                IDLE, AGREE: begin
                    if (w_mm) begin
                        w_state_nxt = w_first_mm;
                        w_run_nxt   = RUN_W'(1);
                    end else begin
                        w_state_nxt = AGREE;
                        w_run_nxt   = '0;
                    end
                end
                MISMATCH: begin
                    if (w_mm) begin
                        w_run_nxt = w_run_inc[RUN_W-1:0];
                        if (w_run_inc == HOLD_V) begin
                            w_state_nxt = FAULT;
                        end
                    end else begin
                        w_state_nxt = AGREE;
                        w_run_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = FAULT;
                end
            endcase
        end
    end

    // Output decode
    always_comb begin
        o_fault = (r_state == FAULT);
        o_state = r_state;
    end

    // Sampled copies are unaffected by clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_e_q <= 1'b0;
            r_f_q <= 1'b0;
        end else if (i_en) begin
            r_e_q <= i_e_in;
            r_f_q <= i_f_in;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mismatch <= 1'b0;
            r_mm_count <= '0;
        end else if (i_clr) begin
            r_mismatch <= 1'b0;
            r_mm_count <= '0;
        end else if (i_en) begin
            r_mismatch <= w_mm;
            if (w_mm && (r_mm_count != '1)) begin
                r_mm_count <= r_mm_count + CNT_W'(1);
            end
        end
    end

    assign o_e_q      = r_e_q;
    assign o_f_q      = r_f_q;
    assign o_mismatch = r_mismatch;
    assign o_mm_count = r_mm_count;

endmodule

// File: tb/tb_dual_driver_checker.sv
// Directed bench for dual_driver_checker: behavioural model feeds a scoreboard
// queue, outputs of an 8-bit and a 4-bit counter instance are checked after each edge.
module tb_dual_driver_checker;

    localparam int unsigned HOLD = 3;

    typedef struct {
        logic       eq;
        logic       fq;
        logic       mm;
        logic       fault;
        logic [1:0] st;
        logic [7:0] c8;
        logic [3:0] c4;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, en, clr, e_in, f_in;
    logic       e_q8, f_q8, mm8, fault8;
    logic [7:0] cnt8;
    logic [1:0] st8;
    logic       e_q4, f_q4, mm4, fault4;
    logic [3:0] cnt4;
    logic [1:0] st4;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    // bench model
    logic       m_eq, m_fq, m_mm;
    logic [1:0] m_st;
    int         m_run, m_c8, m_c4;

    always #5 clk = ~clk;

    dual_driver_checker #(.CNT_W(8), .HOLD(HOLD)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr),
        .i_e_in(e_in), .i_f_in(f_in),
        .o_e_q(e_q8), .o_f_q(f_q8), .o_mismatch(mm8), .o_fault(fault8),
        .o_mm_count(cnt8), .o_state(st8)
    );

    dual_driver_checker #(.CNT_W(4), .HOLD(HOLD)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr),
        .i_e_in(e_in), .i_f_in(f_in),
        .o_e_q(e_q4), .o_f_q(f_q4), .o_mismatch(mm4), .o_fault(fault4),
        .o_mm_count(cnt4), .o_state(st4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_eq = 0; m_fq = 0; m_mm = 0; m_st = 0; m_run = 0; m_c8 = 0; m_c4 = 0;
    endtask

    task automatic step(input logic s_en, input logic s_clr, input logic s_e, input logic s_f);
        exp_t x;
        en = s_en; clr = s_clr; e_in = s_e; f_in = s_f;
        if (s_en) begin
            m_eq = s_e;
            m_fq = s_f;
        end
        if (s_clr) begin
            m_st = 0; m_run = 0; m_c8 = 0; m_c4 = 0; m_mm = 0;
        end else if (s_en) begin
            m_mm = s_e ^ s_f;
            if (m_mm) begin
                if (m_c8 < 255) m_c8++;
                if (m_c4 < 15) m_c4++;
            end
            if (m_st != 3) begin
                if (m_mm) begin
                    m_run++;
                    m_st = (m_run >= HOLD) ? 2'd3 : 2'd2;
                end else begin
                    m_run = 0;
                    m_st  = 1;
                end
            end
        end
        x.eq = m_eq; x.fq = m_fq; x.mm = m_mm; x.fault = (m_st == 3);
        x.st = m_st; x.c8 = 8'(m_c8); x.c4 = 4'(m_c4);
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("e_q", 32'(e_q8), 32'(x.eq));
        chk("f_q", 32'(f_q8), 32'(x.fq));
        chk("mismatch", 32'(mm8), 32'(x.mm));
        chk("fault", 32'(fault8), 32'(x.fault));
        chk("state", 32'(st8), 32'(x.st));
        chk("mm_count8", 32'(cnt8), 32'(x.c8));
        chk("mm_count4", 32'(cnt4), 32'(x.c4));
        chk("state4", 32'(st4), 32'(x.st));
    endtask

    initial begin
        rst = 1; en = 0; clr = 0; e_in = 0; f_in = 0;
        model_reset();
        #12;
        chk("rst_state", 32'(st8), 32'd0);
        chk("rst_count", 32'(cnt8), 32'd0);
        chk("rst_fault", 32'(fault8), 32'd0);
        #4 rst = 0;
        @(posedge clk); #1;

        // agree stream
        for (int i = 0; i < 10; i++) step(1, 0, 1, 1);
        chk("agree_state", 32'(st8), 32'd1);
        chk("agree_count", 32'(cnt8), 32'd0);
        chk("agree_eq", 32'(e_q8 & f_q8), 32'd1);

        // two mismatches then agree
        step(1, 0, 1, 0);
        chk("mm1_state", 32'(st8), 32'd2);
        step(1, 0, 1, 0);
        step(1, 0, 1, 1);
        chk("back_agree", 32'(st8), 32'd1);
        chk("two_mm_count", 32'(cnt8), 32'd2);
        chk("no_fault_yet", 32'(fault8), 32'd0);

        // threshold reached on third consecutive mismatch
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        chk("fault_not_at_2", 32'(fault8), 32'd0);
        step(1, 0, 1, 0);
        chk("fault_at_3", 32'(fault8), 32'd1);
        chk("count_5", 32'(cnt8), 32'd5);
        step(1, 0, 0, 0);
        step(1, 0, 1, 1);
        chk("fault_sticky", 32'(fault8), 32'd1);

        // asynchronous reset mid-cycle
        #3 rst = 1;
        #1;
        model_reset();
        chk("async_state", 32'(st8), 32'd0);
        chk("async_fault", 32'(fault8), 32'd0);
        chk("async_count", 32'(cnt8), 32'd0);
        chk("async_eq", 32'(e_q8 | f_q8 | mm8), 32'd0);
        #2 rst = 0;

        // enable gap keeps the run alive
        step(1, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
        chk("gap_hold_state", 32'(st8), 32'd2);
        step(1, 0, 0, 1);
        step(1, 0, 1, 0);
        chk("gap_fault", 32'(fault8), 32'd1);
        chk("gap_count", 32'(cnt8), 32'd3);

        // clear beats same-cycle mismatch while in FAULT
        step(1, 1, 0, 1);
        chk("clr_state", 32'(st8), 32'd0);
        chk("clr_count", 32'(cnt8), 32'd0);
        chk("clr_mismatch", 32'(mm8), 32'd0);
        chk("clr_fq", 32'(f_q8), 32'd1);

        // saturation on the narrow counter
        for (int i = 0; i < 20; i++) step(1, 0, 1, 0);
        chk("sat4", 32'(cnt4), 32'd15);
        chk("wide20", 32'(cnt8), 32'd20);
        step(1, 0, 0, 1);
        chk("sat4_hold", 32'(cnt4), 32'd15);

        // clear with enable low: copies hold
        step(0, 1, 1, 1);
        chk("clr_noen_eq", 32'(e_q8), 32'd0);
        chk("clr_noen_state", 32'(st8), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
